// File: rtl/ntt_out_serializer.sv
// Serializes one NTT/INTT result polynomial: captures B wide beats right after
// the core's done pulse, then streams the RING_SIZE coefficients in index order
// over a valid/ready port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for done from the core
// CAPTURE | sampling one beat of L lanes per cycle into the buffer
// DRAIN   | presenting buffer[out_idx] on dout until its transfer
module ntt_out_serializer #(
    parameter int DATA_SIZE = 32,
    parameter int PE_NUMBER = 8,
    parameter int RING_SIZE = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              done,
    input  logic [DATA_SIZE*2*PE_NUMBER-1:0]  bram_in,
    output logic [DATA_SIZE-1:0]              dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic                              dout_last,
    output logic                              busy,
    output logic                              overrun
);

    localparam int LANES = 2 * PE_NUMBER;
    localparam int IDX_W = $clog2(RING_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RING_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(RING_SIZE - LANES);
    localparam logic [IDX_W-1:0] LANE_STEP = IDX_W'(LANES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_SIZE-1:0] buffer [RING_SIZE];
    logic [IDX_W-1:0]     wr_base;
    logic [IDX_W-1:0]     out_idx;
    logic [IDX_W-1:0]     next_idx;
    logic [DATA_SIZE-1:0] first_coef;
    logic                 cap_end;
    logic                 xfer;
    logic                 xfer_last;

    assign cap_end   = (state_q == CAPTURE) && (wr_base == LAST_BASE);
    assign xfer      = (state_q == DRAIN) && dout_valid && dout_ready;
    assign xfer_last = xfer && (out_idx == LAST_IDX);
    assign next_idx  = out_idx + IDX_W'(1);
    assign busy      = (state_q != IDLE);

    // With a single beat, buffer[0] is written on the same edge dout loads,
    // so lane 0 has to be taken straight from the input.
    assign first_coef = (LAST_BASE == '0) ? bram_in[DATA_SIZE-1:0] : buffer[0];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (done)      state_d = CAPTURE;
            CAPTURE: if (cap_end)   state_d = DRAIN;
            DRAIN:   if (xfer_last) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Result buffer: lane n of the current beat goes to index wr_base+n; no reset needed
    always_ff @(posedge clk) begin
        if (reset && (state_q == CAPTURE)) begin
            for (int n = 0; n < LANES; n++) begin
                buffer[wr_base + IDX_W'(n)] <= bram_in[DATA_SIZE*n +: DATA_SIZE];
            end
        end
    end

    // Write pointer, output register, drain index and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_base    <= '0;
            out_idx    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done && (state_q != IDLE)) overrun <= 1'b1;
            case (state_q)
                IDLE: begin
                    wr_base <= '0;
                end
                CAPTURE: begin
                    wr_base <= wr_base + LANE_STEP;
                    if (cap_end) begin
                        dout       <= first_coef;
                        dout_valid <= 1'b1;
                        dout_last  <= (LAST_IDX == '0);
                        out_idx    <= '0;
                    end
                end
                DRAIN: begin
                    if (xfer_last) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                    end else if (xfer) begin
                        dout      <= buffer[next_idx];
                        out_idx   <= next_idx;
                        dout_last <= (next_idx == LAST_IDX);
                    end
                end
                default: begin
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ntt_out_serializer.md
NTT_OUT_SERIALIZER -- requirements
Module: ntt_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, coefficient width in bits.
REQ-002 The block SHALL have parameter PE_NUMBER, default 8, butterfly units in the upstream NTT/INTT core. Lanes L = 2*PE_NUMBER.
REQ-003 The block SHALL have parameter RING_SIZE, default 1024, coefficients per polynomial; RING_SIZE is a power of two and a multiple of L. Beats B = RING_SIZE/L.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-low reset, sampled on the rising clk edge.
REQ-007 done  input  1  one-cycle pulse from the NTT/INTT core marking result readout.
REQ-008 bram_in  input  DATA_SIZE*L  one result beat; lane n = bram_in[DATA_SIZE*n +: DATA_SIZE].
REQ-009 dout  output  DATA_SIZE  serialized coefficient.
REQ-010 dout_valid  output  1  dout holds a valid coefficient.
REQ-011 dout_ready  input  1  downstream accepts dout this cycle.
REQ-012 dout_last  output  1  dout is coefficient RING_SIZE-1; qualified by dout_valid.
REQ-013 busy  output  1  high in CAPTURE or DRAIN.
REQ-014 overrun  output  1  sticky: done seen while busy.

Function
REQ-015 The block SHALL implement states IDLE, CAPTURE, DRAIN, held in a registered state variable.
REQ-016 IDLE: done=1 SHALL move to CAPTURE; all other inputs ignored.
REQ-017 CAPTURE: beat m (m=0..B-1) SHALL be sampled on the m-th cycle after the done cycle, unconditionally, with no backpressure to the core.
REQ-018 Lane n of beat m SHALL be stored at buffer index L*m+n.
REQ-019 On the edge capturing beat B-1, the state SHALL become DRAIN, dout SHALL load buffer[0] (forwarded if needed), dout_valid SHALL rise; first dout_valid is therefore B+1 cycles after the done cycle.
REQ-020 DRAIN: a transfer SHALL occur on each edge with dout_valid=1 and dout_ready=1; the next index SHALL load on that edge, so sustained ready yields one coefficient per cycle, no bubbles.
REQ-021 DRAIN: while dout_ready=0, dout, dout_last and dout_valid SHALL hold.
REQ-022 Coefficients SHALL be emitted in index order 0..RING_SIZE-1, each exactly once; dout_last=1 only with index RING_SIZE-1.
REQ-023 The transfer of index RING_SIZE-1 SHALL return the state to IDLE and clear dout_valid, dout_last, busy on the same edge.
REQ-024 A done pulse during CAPTURE or DRAIN, including the cycle of the final transfer, SHALL be ignored and SHALL set overrun; the captured data and its drain are unaffected.
REQ-025 overrun SHALL clear only on reset.
REQ-026 Index counters SHALL be log2(RING_SIZE) bits and SHALL not wrap within one polynomial.
REQ-027 busy SHALL be 1 exactly when the state is CAPTURE or DRAIN.

Reset
REQ-028 reset=0 SHALL force IDLE and dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0 on the next edge, from any state, including mid-CAPTURE and mid-DRAIN.
REQ-029 Buffer contents SHALL not require reset; no stale data SHALL be emitted after reset, since emission requires a new full CAPTURE.
REQ-030 After reset deasserts, a done in the first cycle SHALL be accepted.

Verification
REQ-031 Ramp: done, beat m lane n = L*m+n, dout_ready=1 -> dout_valid rises at cycle 65 after done, dout=0..1023 on consecutive cycles, dout_last only with 1023, busy falls after that transfer.
REQ-032 Backpressure: random dout_ready at 30% duty -> same 0..1023 sequence, no drop or duplicate, dout stable while ready=0.
REQ-033 Overrun: second done at the 10th CAPTURE beat and again mid-DRAIN -> overrun=1, output sequence identical to REQ-031.
REQ-034 Reset mid-operation: reset=0 at beat 20, and separately after 500 transfers -> next cycle dout_valid=0, busy=0, overrun=0; a fresh done with data 0x5A5A0000+index drains that data only.
REQ-035 Back-to-back: done on the cycle after the last transfer -> accepted, second polynomial drains correctly, overrun stays 0.
REQ-036 Golden check: bram_in beats from the INTT result file -> serialized stream equals the reference output file, all 1024 indices matching.
